// File: rtl/cpe_pkg.sv
// Shared types for the processor memory path: word width, arbiter states and port owners.
package cpe_pkg;

   localparam int unsigned WORD = 16;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;

   // A lone request always wins; on a tie, round-robin favours the port that did not go last.
   function automatic owner_t arb_pick(input logic i_req, input logic d_req, input logic rr,
                                       input owner_t last);
      if (i_req && d_req) begin
         if (rr) return (last == OWN_D) ? OWN_I : OWN_D;
         return OWN_D;
      end
      if (d_req) return OWN_D;
      return OWN_I;
   endfunction

endpackage

// File: rtl/mem_arb_lat_ctr.sv
// Loadable down-counter that times the memory read latency; term marks the capture cycle.
module mem_arb_lat_ctr #(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic dec,
   output logic term
);

   localparam int unsigned CW = $clog2(MEM_LAT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(MEM_LAT);
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign term = (cnt == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/load-store arbiter for the single-ported unified memory.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise D always wins.
module mem_port_arbiter
   import cpe_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = WORD,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   arb_state_t state;
   owner_t     owner;
   owner_t     grant;
   logic       lat_term;

`ifdef MEM_ARB_RR_EN
   owner_t last_owner;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_owner <= OWN_I;
      end else if ((state == IDLE) && (i_req || d_req)) begin
         last_owner <= grant;
      end
   end

   always_comb grant = arb_pick(i_req, d_req, 1'b1, last_owner);
`else
   always_comb grant = arb_pick(i_req, d_req, 1'b0, OWN_I);
`endif

   // mem_we stays high through ISSUE only for a store, so it also selects the exit path.
   mem_arb_lat_ctr #(
      .MEM_LAT(MEM_LAT)
   ) u_lat_ctr (
      .clk  (clk),
      .reset(reset),
      .load ((state == ISSUE) && !mem_we),
      .dec  (state == WAIT),
      .term (lat_term)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= OWN_I;
         i_ready   <= 1'b0;
         d_ready   <= 1'b0;
         i_rvalid  <= 1'b0;
         d_rvalid  <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         i_ready  <= 1'b0;
         d_ready  <= 1'b0;
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  state  <= ISSUE;
                  owner  <= grant;
                  mem_en <= 1'b1;
                  if (grant == OWN_D) begin
                     d_ready   <= 1'b1;
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end else begin
                     i_ready  <= 1'b1;
                     mem_addr <= i_addr;
                  end
               end
            end
            ISSUE: begin
               state <= mem_we ? IDLE : WAIT;
            end
            WAIT: begin
               if (lat_term) begin
                  state <= IDLE;
                  if (owner == OWN_D) begin
                     d_rdata  <= mem_rdata;
                     d_rvalid <= 1'b1;
                  end else begin
                     i_rdata  <= mem_rdata;
                     i_rvalid <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule
